// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl
// Purpose  : Sequencer and iterative datapath for MIPS MULT/DIV. Runs a
//            WIDTH-step unsigned shift-add multiply or restoring divide on
//            operand magnitudes, then applies sign correction and loads HI/LO.
//            Signals a one-cycle div0 pulse for a DIV by zero.
// Ports    : clk      - system clock, rising edge
//            reset    - synchronous, active-low reset
//            start    - operation request, sampled only when idle
//            op       - 0 = MULT, 1 = DIV
//            srcA     - rs operand (multiplicand / dividend), signed
//            srcB     - rt operand (multiplier / divisor), signed
//            busy     - high whenever the sequencer is not idle
//            done     - one-cycle pulse, hi/lo valid
//            div0     - one-cycle pulse, DIV requested with srcB == 0
//            hi, lo   - MULT: product high/low; DIV: remainder/quotient
//            hiWrite  - HI load strobe (equals done)
//            loWrite  - LO load strobe (equals done)
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             hiWrite,
    output logic             loWrite
);

    localparam int            CW     = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_op;
    logic             r_sign_a;
    logic             r_sign_b;
    // r_acc_hi: MULT partial product high half / DIV partial remainder.
    // r_acc_lo: MULT multiplier (shifted out) / DIV dividend-to-quotient.
    // r_opb   : MULT multiplicand magnitude / DIV divisor magnitude.
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_opb;

    // Magnitudes; the most negative value maps to 2**(WIDTH-1) exactly.
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    assign w_abs_a = srcA[WIDTH-1] ? (~srcA + 1'b1) : srcA;
    assign w_abs_b = srcB[WIDTH-1] ? (~srcB + 1'b1) : srcB;

    // Multiply step: conditional add into the high half, then shift the
    // whole 2*WIDTH accumulator right by one (carry enters at the top).
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_msum;
    logic [WIDTH-1:0] w_mhi;
    logic [WIDTH-1:0] w_mlo;
    assign w_addend = r_acc_lo[0] ? r_opb : '0;
    assign w_msum   = {1'b0, r_acc_hi} + {1'b0, w_addend};
    assign w_mhi    = w_msum[WIDTH:1];
    assign w_mlo    = {w_msum[0], r_acc_lo[WIDTH-1:1]};

    // Restoring divide step: shift the next dividend bit into the remainder,
    // trial-subtract, keep the difference when it did not borrow.
    logic [WIDTH:0]   w_dshift;
    logic [WIDTH:0]   w_ddiff;
    logic             w_dge;
    logic [WIDTH-1:0] w_dhi;
    logic [WIDTH-1:0] w_dlo;
    assign w_dshift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_ddiff  = w_dshift - {1'b0, r_opb};
    assign w_dge    = ~w_ddiff[WIDTH];
    assign w_dhi    = w_dge ? w_ddiff[WIDTH-1:0] : w_dshift[WIDTH-1:0];
    assign w_dlo    = {r_acc_lo[WIDTH-2:0], w_dge};

    logic [WIDTH-1:0] w_nhi;
    logic [WIDTH-1:0] w_nlo;
    assign w_nhi = r_op ? w_dhi : w_mhi;
    assign w_nlo = r_op ? w_dlo : w_mlo;

    // Sign correction applied to the result of the final iteration.
    logic             w_neg;
    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0] w_fhi;
    logic [WIDTH-1:0] w_flo;
    assign w_neg      = r_sign_a ^ r_sign_b;
    assign w_prod_neg = ~{w_nhi, w_nlo} + 1'b1;
    always_comb begin
        w_fhi = w_nhi;
        w_flo = w_nlo;
        if (r_op) begin
            // Remainder follows the dividend sign, quotient the sign XOR.
            if (r_sign_a) w_fhi = ~w_nhi + 1'b1;
            if (w_neg)    w_flo = ~w_nlo + 1'b1;
        end else if (w_neg) begin
            w_fhi = w_prod_neg[2*WIDTH-1:WIDTH];
            w_flo = w_prod_neg[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opb    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div0     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (op && (srcB == '0)) begin
                            r_state <= S_ERR;
                            div0    <= 1'b1;
                        end else begin
                            r_state  <= S_CALC;
                            r_cnt    <= '0;
                            r_op     <= op;
                            r_sign_a <= srcA[WIDTH-1];
                            r_sign_b <= srcB[WIDTH-1];
                            r_acc_hi <= '0;
                            r_acc_lo <= op ? w_abs_a : w_abs_b;
                            r_opb    <= op ? w_abs_b : w_abs_a;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt    <= r_cnt + 1'b1;
                    r_acc_hi <= w_nhi;
                    r_acc_lo <= w_nlo;
                    if (r_cnt == c_last) begin
                        r_state <= S_FIN;
                        done    <= 1'b1;
                        hi      <= w_fhi;
                        lo      <= w_flo;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                S_ERR: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign hiWrite = done;
    assign loWrite = done;

endmodule
`default_nettype wire
